fifo_sync: RTL and testbench



---
 rtl/fifo_sync_pkg.sv | 11 +
 rtl/fifo_sync_bram.sv | 28 ++
 rtl/fifo_sync.sv | 130 +++++++++++++
 tb/tb_fifo_sync.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared constants and helpers for the single-clock FIFO and its memory.
package fifo_sync_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int addr_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_sync_bram.sv
// Simple dual-port block RAM: one synchronous write port, one registered read port.
module fifo_sync_bram
  import fifo_sync_pkg::*;
#(
  parameter int P_DEPTH = 1024,
  parameter int P_WIDTH = 8
) (
  input  logic                          wr_clk,
  input  logic                          wr_en,
  input  logic [addr_bits(P_DEPTH)-1:0] wr_addr,
  input  logic [P_WIDTH-1:0]            wr_data,
  input  logic                          rd_clk,
  input  logic                          rd_en,
  input  logic [addr_bits(P_DEPTH)-1:0] rd_addr,
  output logic [P_WIDTH-1:0]            rd_data
);

  logic [P_WIDTH-1:0] mem [P_DEPTH];

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered flags, thresholds, occupancy count and
// either a registered (2-stage) read or a first-word-fall-through prefetch.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int P_DEPTH  = 1024,
  parameter int P_WIDTH  = 8,
  parameter int P_FWFT   = FIFO_STD,
  parameter int P_AFULL  = P_DEPTH - 4,
  parameter int P_AEMPTY = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [P_WIDTH-1:0]          wr_data,
  output logic                        full,
  output logic                        almost_full,
  output logic                        overflow,
  input  logic                        rd_en,
  output logic [P_WIDTH-1:0]          rd_data,
  output logic                        rd_valid,
  output logic                        empty,
  output logic                        almost_empty,
  output logic                        underflow,
  output logic [addr_bits(P_DEPTH):0] count
);

  localparam int AW = addr_bits(P_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH  = CW'(P_DEPTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(P_AFULL);
  localparam logic [CW-1:0] C_AEMPTY = CW'(P_AEMPTY);
  localparam bit FWFT = (P_FWFT == FIFO_FWFT);

  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      ram_cnt, count_nxt;
  logic [P_WIDTH-1:0] ram_q, s1_data, s1_byp_data;
  logic               rd_pend, s1_v, s1_byp;
  logic               wr_acc, rd_acc, ram_we, ram_re;
  logic               move, fetch, byp, out_v_nxt;

  fifo_sync_bram #(
    .P_DEPTH (P_DEPTH),
    .P_WIDTH (P_WIDTH)
  ) u_bram (
    .wr_clk  (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_clk  (clk),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CW'(1);
    else if (!wr_acc && rd_acc) count_nxt = count - CW'(1);
    s1_data   = s1_byp ? s1_byp_data : ram_q;
    ram_we    = wr_acc;
    ram_re    = rd_acc;
    move      = 1'b0;
    fetch     = 1'b0;
    byp       = 1'b0;
    out_v_nxt = 1'b0;
    if (FWFT) begin
      // rd_valid doubles as the output-stage valid; stage 1 is the RAM read register
      move      = s1_v && (!rd_valid || rd_acc);
      fetch     = (ram_cnt != '0) && (!s1_v || move);
      // With the RAM drained and a word already showing, a write lands straight
      // in stage 1 so a pop next cycle has no bubble.
      byp       = wr_acc && (ram_cnt == '0) && rd_valid && (!s1_v || move);
      out_v_nxt = move || (rd_valid && !rd_acc);
      ram_we    = wr_acc && !byp;
      ram_re    = fetch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_pend      <= 1'b0;
      s1_v         <= 1'b0;
      s1_byp       <= 1'b0;
      s1_byp_data  <= '0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + AW'(1);
      if (ram_re) rd_ptr <= rd_ptr + AW'(1);
      ram_cnt      <= ram_cnt + CW'(ram_we) - CW'(ram_re);
      count        <= count_nxt;
      full         <= (count_nxt == C_DEPTH);
      almost_full  <= (count_nxt >= C_AFULL);
      almost_empty <= (count_nxt <= C_AEMPTY);
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
      if (FWFT) begin
        empty    <= !out_v_nxt;
        rd_valid <= out_v_nxt;
        if (fetch || byp) s1_v <= 1'b1;
        else if (move)    s1_v <= 1'b0;
        if (fetch) s1_byp <= 1'b0;
        else if (byp) begin
          s1_byp      <= 1'b1;
          s1_byp_data <= wr_data;
        end
        if (move) rd_data <= s1_data;
      end else begin
        empty    <= (count_nxt == '0);
        rd_pend  <= rd_acc;
        rd_valid <= rd_pend;
        if (rd_pend) rd_data <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: standard, FWFT and custom-threshold instances at depth 16.
module tb_fifo_sync;

  localparam int D  = 16;
  localparam int W  = 8;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic         a_wr_en = 1'b0, a_rd_en = 1'b0;
  logic [W-1:0] a_wr_data = '0;
  logic         a_full, a_afull, a_ovf, a_rd_valid, a_empty, a_aempty, a_unf;
  logic [W-1:0] a_rd_data;
  logic [CW-1:0] a_count;

  logic         b_wr_en = 1'b0, b_rd_en = 1'b0;
  logic [W-1:0] b_wr_data = '0;
  logic         b_full, b_afull, b_ovf, b_rd_valid, b_empty, b_aempty, b_unf;
  logic [W-1:0] b_rd_data;
  logic [CW-1:0] b_count;

  logic         c_wr_en = 1'b0, c_rd_en = 1'b0;
  logic [W-1:0] c_wr_data = '0;
  logic         c_full, c_afull, c_ovf, c_rd_valid, c_empty, c_aempty, c_unf;
  logic [W-1:0] c_rd_data;
  logic [CW-1:0] c_count;

  logic [W-1:0] a_q[$];
  logic [W-1:0] b_q[$];

  fifo_sync #(.P_DEPTH(D), .P_WIDTH(W), .P_FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .full(a_full),
    .almost_full(a_afull), .overflow(a_ovf), .rd_en(a_rd_en), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .empty(a_empty), .almost_empty(a_aempty),
    .underflow(a_unf), .count(a_count));

  fifo_sync #(.P_DEPTH(D), .P_WIDTH(W), .P_FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .full(b_full),
    .almost_full(b_afull), .overflow(b_ovf), .rd_en(b_rd_en), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .empty(b_empty), .almost_empty(b_aempty),
    .underflow(b_unf), .count(b_count));

  fifo_sync #(.P_DEPTH(D), .P_WIDTH(W), .P_FWFT(0), .P_AFULL(10), .P_AEMPTY(2)) u_thr (
    .clk(clk), .rst(rst), .wr_en(c_wr_en), .wr_data(c_wr_data), .full(c_full),
    .almost_full(c_afull), .overflow(c_ovf), .rd_en(c_rd_en), .rd_data(c_rd_data),
    .rd_valid(c_rd_valid), .empty(c_empty), .almost_empty(c_aempty),
    .underflow(c_unf), .count(c_count));

  // Standard-mode read data checked against the scoreboard whenever rd_valid pulses
  always @(negedge clk) begin
    if (!rst && a_rd_valid === 1'b1) begin
      n_tests++;
      if (a_q.size() == 0) begin
        n_fail++;
        $display("FAIL std_unexpected_read: got %0h expected no data", a_rd_data);
      end else begin
        logic [W-1:0] exp;
        exp = a_q.pop_front();
        if (a_rd_data !== exp) begin
          n_fail++;
          $display("FAIL std_rd_data: got %0h expected %0h", a_rd_data, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({a_empty, a_aempty, a_full, a_afull, a_ovf, a_unf, a_rd_valid} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_flags_std: got %b expected 1100000",
               {a_empty, a_aempty, a_full, a_afull, a_ovf, a_unf, a_rd_valid});
    end
    n_tests++;
    if (a_count !== '0 || a_rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_count_data_std: got count %0d data %0h expected 0 0", a_count, a_rd_data);
    end
    n_tests++;
    if ({b_empty, b_aempty, b_full, b_afull, b_ovf, b_unf, b_rd_valid} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_flags_fwft: got %b expected 1100000",
               {b_empty, b_aempty, b_full, b_afull, b_ovf, b_unf, b_rd_valid});
    end
    n_tests++;
    if (b_count !== '0 || b_rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_count_data_fwft: got count %0d data %0h expected 0 0", b_count, b_rd_data);
    end
    n_tests++;
    if ({c_empty, c_aempty, c_full, c_afull, c_count} !== {4'b1100, CW'(0)}) begin
      n_fail++;
      $display("FAIL reset_thr: got %b expected 1100 count 0", {c_empty, c_aempty, c_full, c_afull, c_count});
    end
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= D; i++) begin
      a_wr_en = 1'b1;
      a_wr_data = W'(i);
      a_q.push_back(W'(i));
      tick();
      n_tests++;
      if (a_count !== CW'(i) || a_empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_count: got %0d empty %b expected %0d empty 0", a_count, a_empty, i);
      end
      n_tests++;
      if (a_afull !== (i >= 12 ? 1'b1 : 1'b0) || a_full !== (i == D ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL fill_flags at %0d: got afull %b full %b expected %b %b",
                 i, a_afull, a_full, (i >= 12), (i == D));
      end
    end
    a_wr_en = 1'b0;
    for (int t = 0; t < D + 2; t++) begin
      a_rd_en = (t < D);
      tick();
      n_tests++;
      if (a_rd_valid !== ((t >= 1 && t <= D) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL drain_rd_valid at %0d: got %b expected %b", t, a_rd_valid, (t >= 1 && t <= D));
      end
      if (t < D) begin
        n_tests++;
        if (a_count !== CW'(D - 1 - t)) begin
          n_fail++;
          $display("FAIL drain_count: got %0d expected %0d", a_count, D - 1 - t);
        end
      end
    end
    a_rd_en = 1'b0;
    n_tests++;
    if (a_empty !== 1'b1 || a_aempty !== 1'b1 || a_count !== '0) begin
      n_fail++;
      $display("FAIL drain_empty: got empty %b aempty %b count %0d expected 1 1 0", a_empty, a_aempty, a_count);
    end
  endtask

  task automatic test_over_under();
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    n_tests++;
    if (a_unf !== 1'b1 || a_count !== '0) begin
      n_fail++;
      $display("FAIL underflow_pulse: got unf %b count %0d expected 1 0", a_unf, a_count);
    end
    tick();
    n_tests++;
    if (a_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_width: got %b expected 0", a_unf);
    end
    for (int i = 0; i < D; i++) begin
      a_wr_en = 1'b1;
      a_wr_data = W'(8'h20 + i);
      a_q.push_back(a_wr_data);
      tick();
    end
    a_wr_data = 8'hEE;
    tick();
    n_tests++;
    if (a_ovf !== 1'b1 || a_count !== CW'(D) || a_full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_pulse: got ovf %b count %0d full %b expected 1 16 1", a_ovf, a_count, a_full);
    end
    a_wr_en = 1'b0;
    tick();
    n_tests++;
    if (a_ovf !== 1'b0 || a_count !== CW'(D)) begin
      n_fail++;
      $display("FAIL overflow_width: got ovf %b count %0d expected 0 16", a_ovf, a_count);
    end
  endtask

  task automatic test_back_to_back();
    a_wr_en = 1'b1;
    a_wr_data = 8'h77;
    a_rd_en = 1'b1;
    tick();
    n_tests++;
    if (a_count !== CW'(D - 1) || a_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_at_full: got count %0d ovf %b expected 15 1", a_count, a_ovf);
    end
    a_wr_en = 1'b0;
    repeat (7) tick();
    a_rd_en = 1'b0;
    n_tests++;
    if (a_count !== CW'(8)) begin
      n_fail++;
      $display("FAIL rw_setup_count: got %0d expected 8", a_count);
    end
    for (int i = 0; i < 100; i++) begin
      a_wr_en = 1'b1;
      a_wr_data = W'($urandom);
      a_q.push_back(a_wr_data);
      a_rd_en = 1'b1;
      tick();
      n_tests++;
      if (a_count !== CW'(8)) begin
        n_fail++;
        $display("FAIL rw_hold_count at %0d: got %0d expected 8", i, a_count);
      end
    end
    a_wr_en = 1'b0;
    repeat (8) tick();
    a_rd_en = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (a_count !== '0 || a_empty !== 1'b1 || a_q.size() != 0) begin
      n_fail++;
      $display("FAIL rw_final: got count %0d empty %b pending %0d expected 0 1 0", a_count, a_empty, a_q.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      a_wr_en = 1'b1;
      a_wr_data = W'(8'h40 + i);
      a_q.push_back(a_wr_data);
      tick();
    end
    a_wr_en = 1'b0;
    a_rd_en = 1'b1;
    tick();
    n_tests++;
    if (a_count !== CW'(9)) begin
      n_fail++;
      $display("FAIL rstmid_pre_count: got %0d expected 9", a_count);
    end
    rst = 1'b1;
    a_q.delete();
    tick();
    n_tests++;
    if (a_count !== '0 || a_empty !== 1'b1 || a_rd_valid !== 1'b0 || a_rd_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_state: got count %0d empty %b valid %b data %0h expected 0 1 0 0",
               a_count, a_empty, a_rd_valid, a_rd_data);
    end
    rst = 1'b0;
    a_rd_en = 1'b0;
    a_wr_en = 1'b1;
    a_wr_data = 8'hC3;
    a_q.push_back(8'hC3);
    tick();
    a_wr_en = 1'b0;
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    tick();
    n_tests++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL rstmid_new_data: got valid %b data %0h expected 1 c3", a_rd_valid, a_rd_data);
    end
    repeat (2) tick();
    n_tests++;
    if (a_q.size() != 0 || a_count !== '0) begin
      n_fail++;
      $display("FAIL rstmid_drained: got pending %0d count %0d expected 0 0", a_q.size(), a_count);
    end
  endtask

  task automatic test_fwft();
    logic [W-1:0] exp;
    b_wr_en = 1'b1;
    b_wr_data = 8'hA5;
    b_q.push_back(8'hA5);
    tick();
    b_wr_en = 1'b0;
    n_tests++;
    if (b_empty !== 1'b1 || b_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL fwft_edge_n: got empty %b count %0d expected 1 1", b_empty, b_count);
    end
    tick();
    n_tests++;
    if (b_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL fwft_edge_n1: got empty %b expected 1", b_empty);
    end
    tick();
    n_tests++;
    if (b_empty !== 1'b0 || b_rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fwft_edge_n2: got empty %b valid %b expected 0 1", b_empty, b_rd_valid);
    end
    exp = b_q.pop_front();
    n_tests++;
    if (b_rd_data !== exp) begin
      n_fail++;
      $display("FAIL fwft_single_data: got %0h expected %0h", b_rd_data, exp);
    end
    b_rd_en = 1'b1;
    tick();
    b_rd_en = 1'b0;
    n_tests++;
    if (b_empty !== 1'b1 || b_count !== '0) begin
      n_fail++;
      $display("FAIL fwft_single_pop: got empty %b count %0d expected 1 0", b_empty, b_count);
    end
    for (int i = 0; i < 5; i++) begin
      b_wr_en = 1'b1;
      b_wr_data = W'(8'h50 + i);
      b_q.push_back(b_wr_data);
      tick();
    end
    b_wr_en = 1'b0;
    n_tests++;
    if (b_count !== CW'(5)) begin
      n_fail++;
      $display("FAIL fwft_burst_count: got %0d expected 5", b_count);
    end
    b_rd_en = 1'b1;
    for (int t = 0; t < 5; t++) begin
      n_tests++;
      if (b_empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fwft_gap at %0d: got empty %b expected 0", t, b_empty);
      end
      exp = b_q.pop_front();
      n_tests++;
      if (b_rd_data !== exp) begin
        n_fail++;
        $display("FAIL fwft_burst_data at %0d: got %0h expected %0h", t, b_rd_data, exp);
      end
      tick();
    end
    n_tests++;
    if (b_empty !== 1'b1 || b_count !== '0) begin
      n_fail++;
      $display("FAIL fwft_burst_end: got empty %b count %0d expected 1 0", b_empty, b_count);
    end
    tick();
    b_rd_en = 1'b0;
    n_tests++;
    if (b_unf !== 1'b1 || b_count !== '0) begin
      n_fail++;
      $display("FAIL fwft_underflow: got unf %b count %0d expected 1 0", b_unf, b_count);
    end
  endtask

  task automatic test_thresholds();
    for (int i = 1; i <= 11; i++) begin
      c_wr_en = 1'b1;
      c_wr_data = W'(i);
      tick();
      n_tests++;
      if (c_count !== CW'(i) || c_aempty !== (i <= 2 ? 1'b1 : 1'b0) || c_afull !== (i >= 10 ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL thr_up at %0d: got count %0d aempty %b afull %b expected %b %b",
                 i, c_count, c_aempty, c_afull, (i <= 2), (i >= 10));
      end
    end
    c_wr_en = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      c_rd_en = 1'b1;
      tick();
      n_tests++;
      if (c_count !== CW'(i) || c_aempty !== (i <= 2 ? 1'b1 : 1'b0) || c_afull !== (i >= 10 ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL thr_down at %0d: got count %0d aempty %b afull %b expected %b %b",
                 i, c_count, c_aempty, c_afull, (i <= 2), (i >= 10));
      end
    end
    c_rd_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_over_under();
    test_back_to_back();
    test_reset_mid();
    test_fwft();
    test_thresholds();
    n_tests++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d/%0d pending expected 0/0", a_q.size(), b_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
